// File: rtl/i2c_controller_pkg.sv
// -----------------------------------------------------------------------------
// i2c_controller_pkg
// Shared definitions for the bit-level I2C master:
//   - instruction encodings issued by device drivers on instr_i
//   - controller FSM state encodings
//   - quarter-slot indices within one SCL bit period
//   - small helpers used by the controller datapath
// No ports; imported with `import i2c_controller_pkg::*;`.
// -----------------------------------------------------------------------------
package i2c_controller_pkg;

    typedef enum logic [1:0] {
        INST_START_TX   = 2'd0,
        INST_STOP_TX    = 2'd1,
        INST_READ_BYTE  = 2'd2,
        INST_WRITE_BYTE = 2'd3
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_STOP  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    // Quarter indices inside one bit slot.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Slots 0..7 carry data, slot 8 is the acknowledge slot.
    localparam logic [3:0] LastSlot = 4'd8;

    function automatic state_t instr_to_state(input instr_t instr);
        state_t s;
        s = ST_IDLE;
        case (instr)
            INST_START_TX:   s = ST_START;
            INST_STOP_TX:    s = ST_STOP;
            INST_READ_BYTE:  s = ST_READ;
            INST_WRITE_BYTE: s = ST_WRITE;
            default:         s = ST_IDLE;
        endcase
        return s;
    endfunction

    // In data/ack slots SCL is released during the two middle quarters only.
    function automatic logic scl_high_quarter(input logic [1:0] q);
        return (q == Q1) || (q == Q2);
    endfunction

endpackage

// File: rtl/i2c_controller_if.sv
// -----------------------------------------------------------------------------
// i2c_controller_if
// Bundles the driver request/response handshake and the open-drain pin
// controls of one I2C bus.
//   instr_i    : 2-bit instruction (see instr_t)
//   enable_i   : one-cycle request strobe
//   byte_i     : byte to send for WRITE_BYTE
//   byte_o     : last byte received by READ_BYTE
//   complete_o : high = idle/done, low = busy
//   ack_err_o  : last WRITE_BYTE saw NACK
//   scl_oe_o   : 1 = pull SCL low
//   sda_oe_o   : 1 = pull SDA low
//   sda_i      : sampled SDA pin
//   scl_i      : sampled SCL pin (clock stretching only)
// modport master : driver plus board-pin side
// modport slave  : the controller
// -----------------------------------------------------------------------------
interface i2c_controller_if;
    logic [1:0] instr_i;
    logic       enable_i;
    logic [7:0] byte_i;
    logic [7:0] byte_o;
    logic       complete_o;
    logic       ack_err_o;
    logic       scl_oe_o;
    logic       sda_oe_o;
    logic       sda_i;
    logic       scl_i;

    modport master (
        output instr_i, enable_i, byte_i, sda_i, scl_i,
        input  byte_o, complete_o, ack_err_o, scl_oe_o, sda_oe_o
    );

    modport slave (
        input  instr_i, enable_i, byte_i, sda_i, scl_i,
        output byte_o, complete_o, ack_err_o, scl_oe_o, sda_oe_o
    );
endinterface

// File: rtl/i2c_controller_quarter_tick.sv
// -----------------------------------------------------------------------------
// i2c_quarter_tick
// Divides the system clock into quarter-bit periods of QuarterPeriod cycles
// and tracks the quarter index 0..3 within the current bit slot.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset
//   restart : force count and quarter to 0 (held while the controller idles)
//   hold    : freeze the count while it sits at 0 (SCL clock stretching)
//   tick    : one-cycle pulse in the last cycle of every quarter
//   quarter : current quarter index 0..3
// -----------------------------------------------------------------------------
module i2c_quarter_tick #(
    parameter int QuarterPeriod = 67
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       restart,
    input  logic       hold,
    output logic       tick,
    output logic [1:0] quarter
);
    localparam int CntWidth = $clog2(QuarterPeriod);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(QuarterPeriod - 1);

    logic [CntWidth-1:0] count_reg, count_next;
    logic [1:0]          quarter_reg, quarter_next;

    // QuarterPeriod >= 2, so the last count is never 0 and a held counter
    // can never produce a tick.
    assign tick    = !restart && (count_reg == CntLast);
    assign quarter = quarter_reg;

    always_comb begin
        count_next   = count_reg;
        quarter_next = quarter_reg;
        if (restart) begin
            count_next   = '0;
            quarter_next = 2'd0;
        end else if (hold && (count_reg == '0)) begin
            count_next   = count_reg;
        end else if (tick) begin
            count_next   = '0;
            quarter_next = quarter_reg + 2'd1;
        end else begin
            count_next   = count_reg + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg   <= '0;
            quarter_reg <= 2'd0;
        end else begin
            count_reg   <= count_next;
            quarter_reg <= quarter_next;
        end
    end
endmodule

// File: rtl/i2c_controller.sv
// -----------------------------------------------------------------------------
// i2c_controller
// Bit-level I2C master. Executes one instruction at a time (START, STOP,
// READ_BYTE, WRITE_BYTE) and converts it into open-drain SCL/SDA controls.
// Each bit slot is four quarters of QuarterPeriod clocks.
//   clk_i : system clock
//   rst_i : synchronous active-high reset (aborts any instruction)
//   bus   : i2c_controller_if.slave (request handshake + pin controls)
// Optional build macro I2C_CLK_STRETCH_EN: while SCL is released, the quarter
// counter waits at 0 until the SCL pin reads high (target clock stretching).
// Without it scl_i is ignored.
// -----------------------------------------------------------------------------
module i2c_controller
    import i2c_controller_pkg::*;
#(
    parameter int QuarterPeriod = 67
) (
    input  logic              clk_i,
    input  logic              rst_i,
    i2c_controller_if.slave   bus
);
    state_t     state_reg, state_next;
    logic [3:0] bit_reg, bit_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] byte_reg, byte_next;
    logic       ack_err_reg, ack_err_next;
    logic       ack_sample_reg, ack_sample_next;
    logic       complete_reg, complete_next;
    // Line levels remembered from the last busy cycle; driven while idle so
    // SCL stays low and SDA keeps its level between instructions.
    logic       scl_hold_reg, scl_hold_next;
    logic       sda_hold_reg, sda_hold_next;

    logic       scl_pull, sda_pull;
    logic       tick;
    logic [1:0] quarter;
    logic       tick_restart;
    logic       tick_hold;

    assign tick_restart = (state_reg == ST_IDLE);

`ifdef I2C_CLK_STRETCH_EN
    assign tick_hold = (state_reg != ST_IDLE) && !scl_pull && !bus.scl_i;
`else
    assign tick_hold = 1'b0;
`endif

    i2c_quarter_tick #(
        .QuarterPeriod (QuarterPeriod)
    ) u_tick (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .restart (tick_restart),
        .hold    (tick_hold),
        .tick    (tick),
        .quarter (quarter)
    );

    // Pin waveform for the current state/quarter/slot.
    always_comb begin
        scl_pull = scl_hold_reg;
        sda_pull = sda_hold_reg;
        case (state_reg)
            ST_START: begin
                scl_pull = (quarter == Q0) || (quarter == Q3);
                sda_pull = (quarter == Q2) || (quarter == Q3);
            end
            ST_STOP: begin
                scl_pull = (quarter == Q0);
                sda_pull = (quarter == Q0) || (quarter == Q1);
            end
            ST_WRITE: begin
                scl_pull = !scl_high_quarter(quarter);
                // Data goes out MSB first from the shift register; the
                // acknowledge slot is left to the target.
                sda_pull = (bit_reg != LastSlot) && !shift_reg[7];
            end
            ST_READ: begin
                scl_pull = !scl_high_quarter(quarter);
                // Release during data, drive ACK in the last slot.
                sda_pull = (bit_reg == LastSlot);
            end
            default: begin
                scl_pull = scl_hold_reg;
                sda_pull = sda_hold_reg;
            end
        endcase
    end

    // Next-state and datapath.
    always_comb begin
        state_next      = state_reg;
        bit_next        = bit_reg;
        shift_next      = shift_reg;
        byte_next       = byte_reg;
        ack_err_next    = ack_err_reg;
        ack_sample_next = ack_sample_reg;
        complete_next   = complete_reg;
        scl_hold_next   = scl_hold_reg;
        sda_hold_next   = sda_hold_reg;

        if (state_reg != ST_IDLE) begin
            scl_hold_next = scl_pull;
            sda_hold_next = sda_pull;
        end

        case (state_reg)
            ST_IDLE: begin
                // complete_o rises one cycle after the FSM returns here; a
                // request coinciding with that rise is not accepted.
                complete_next = 1'b1;
                if (complete_reg && bus.enable_i) begin
                    state_next    = instr_to_state(instr_t'(bus.instr_i));
                    bit_next      = 4'd0;
                    shift_next    = bus.byte_i;
                    complete_next = 1'b0;
                end
            end
            ST_START, ST_STOP: begin
                if (tick && (quarter == Q3)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE, ST_READ: begin
                if (tick) begin
                    // q1 -> q2 boundary: SCL has been high for a full quarter.
                    if (quarter == Q1) begin
                        if (bit_reg == LastSlot) begin
                            if (state_reg == ST_WRITE) begin
                                ack_sample_next = bus.sda_i;
                            end
                        end else if (state_reg == ST_READ) begin
                            shift_next = {shift_reg[6:0], bus.sda_i};
                        end
                    end
                    if (quarter == Q3) begin
                        if (bit_reg == LastSlot) begin
                            state_next = ST_IDLE;
                            if (state_reg == ST_READ) begin
                                byte_next = shift_reg;
                            end else begin
                                ack_err_next = ack_sample_reg;
                            end
                        end else begin
                            bit_next = bit_reg + 4'd1;
                            if (state_reg == ST_WRITE) begin
                                shift_next = {shift_reg[6:0], 1'b0};
                            end
                        end
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            bit_reg        <= 4'd0;
            shift_reg      <= 8'h00;
            byte_reg       <= 8'h00;
            ack_err_reg    <= 1'b0;
            ack_sample_reg <= 1'b0;
            complete_reg   <= 1'b1;
            scl_hold_reg   <= 1'b0;
            sda_hold_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_reg        <= bit_next;
            shift_reg      <= shift_next;
            byte_reg       <= byte_next;
            ack_err_reg    <= ack_err_next;
            ack_sample_reg <= ack_sample_next;
            complete_reg   <= complete_next;
            scl_hold_reg   <= scl_hold_next;
            sda_hold_reg   <= sda_hold_next;
        end
    end

    assign bus.scl_oe_o   = scl_pull;
    assign bus.sda_oe_o   = sda_pull;
    assign bus.byte_o     = byte_reg;
    assign bus.complete_o = complete_reg;
    assign bus.ack_err_o  = ack_err_reg;

endmodule
